// File: rtl/alu_result_stage.sv
//------------------------------------------------------------------------------
// Module      : alu_result_stage
// Description : Two-entry in-order result FIFO between the ALU and Z writeback,
//               with zero/negative flags captured at push time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_lo,
    input  logic [WIDTH-1:0] in_hi,
    input  logic             in_wide,
    input  logic [4:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] zlo_out,
    output logic [WIDTH-1:0] zhi_out,
    output logic [4:0]       out_op,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic [1:0]       count,
    output logic [15:0]      done_cnt
);

    localparam logic [1:0] C_FULL = 2'd2;

    logic [WIDTH-1:0] lo_q   [2];
    logic [WIDTH-1:0] hi_q   [2];
    logic [4:0]       op_q   [2];
    logic             zero_q [2];
    logic             neg_q  [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [15:0]      done_q;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_hi;
    logic             w_zero;
    logic             w_neg;

    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Narrow results store a zero high half so flags and outputs never see in_hi.
    assign w_hi   = in_wide ? in_hi : '0;
    assign w_zero = in_wide ? ((in_hi == '0) && (in_lo == '0)) : (in_lo == '0);
    assign w_neg  = in_wide ? in_hi[WIDTH-1] : in_lo[WIDTH-1];

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 2; i++) begin
                lo_q[i]   <= '0;
                hi_q[i]   <= '0;
                op_q[i]   <= '0;
                zero_q[i] <= 1'b0;
                neg_q[i]  <= 1'b0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            done_q  <= 16'd0;
        end else begin
            if (w_push) begin
                lo_q[wptr_q]   <= in_lo;
                hi_q[wptr_q]   <= w_hi;
                op_q[wptr_q]   <= in_op;
                zero_q[wptr_q] <= w_zero;
                neg_q[wptr_q]  <= w_neg;
                wptr_q         <= ~wptr_q;
            end
            if (w_pop) begin
                rptr_q <= ~rptr_q;
                done_q <= done_q + 16'd1;
            end
            count_q <= count_d;
        end
    end

    // Stale storage of consumed entries must not leak out while empty.
    assign zlo_out   = out_valid ? lo_q[rptr_q]   : '0;
    assign zhi_out   = out_valid ? hi_q[rptr_q]   : '0;
    assign out_op    = out_valid ? op_q[rptr_q]   : 5'd0;
    assign flag_zero = out_valid ? zero_q[rptr_q] : 1'b0;
    assign flag_neg  = out_valid ? neg_q[rptr_q]  : 1'b0;
    assign count     = count_q;
    assign done_cnt  = done_q;

endmodule

`default_nettype wire
